hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage RV32 core; successor to the single-cycle load-use detector.

---
 rtl/hazard_ctrl_pkg.sv | 30 +++
 rtl/hazard_fwd_sel.sv | 23 ++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the RV32 pipeline hazard controller: forwarding selects,
// FSM state codes and the packed control bundle driven by the FSM.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] HZ_IDLE     = 2'd0;
  localparam logic [1:0] HZ_LU_HOLD  = 2'd1;
  localparam logic [1:0] HZ_MEM_WAIT = 2'd2;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic bubble_ex;
    logic flush_id;
  } hz_ctl_t;

  // The younger producer (MEM) holds the newer value, so it wins over WB.
  function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit)
      return FWD_MEM;
    else if (wb_hit)
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// EX-stage operand forwarding select for a single source register.
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_NUM_WIDTH = 5
) (
  input  logic [REG_NUM_WIDTH-1:0] src,
  input  logic [REG_NUM_WIDTH-1:0] mem_rd,
  input  logic                     mem_reg_write,
  input  logic [REG_NUM_WIDTH-1:0] wb_rd,
  input  logic                     wb_reg_write,
  output logic [1:0]               sel
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hard-wired zero, so a write to it never produces a forwardable value.
  assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == src);
  assign wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == src);
  assign sel     = fwd_pick(mem_hit, wb_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls of configurable length, data-memory
// wait-state freeze, taken-branch flush, forwarding selects and a stall perf counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_NUM_WIDTH = 5,
  parameter int LOAD_STALL    = 1,
  parameter int PERF_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_NUM_WIDTH-1:0] id_rs1,
  input  logic [REG_NUM_WIDTH-1:0] id_rs2,
  input  logic                     id_rs1_used,
  input  logic                     id_rs2_used,
  input  logic [REG_NUM_WIDTH-1:0] ex_rd,
  input  logic                     ex_mem_read,
  input  logic [REG_NUM_WIDTH-1:0] ex_rs1,
  input  logic [REG_NUM_WIDTH-1:0] ex_rs2,
  input  logic [REG_NUM_WIDTH-1:0] mem_rd,
  input  logic                     mem_reg_write,
  input  logic [REG_NUM_WIDTH-1:0] wb_rd,
  input  logic                     wb_reg_write,
  input  logic                     mem_busy,
  input  logic                     branch_taken,
  output logic                     stall_if,
  output logic                     stall_id,
  output logic                     bubble_ex,
  output logic                     flush_id,
  output logic [1:0]               fwd_a,
  output logic [1:0]               fwd_b,
  output logic                     hazard,
  output logic [PERF_WIDTH-1:0]    stall_cycles
);

  localparam int CW = $clog2(LOAD_STALL + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_STALL - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    state;
  logic [1:0]    ret_state;
  logic [1:0]    eff_state;
  logic [1:0]    next_state;
  logic [1:0]    next_ret;
  logic [CW-1:0] cnt;
  logic [CW-1:0] next_cnt;
  logic          lu;
  hz_ctl_t       ctl;
  logic [1:0]    fwd_a_raw;
  logic [1:0]    fwd_b_raw;

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

  // Leaving MEM_WAIT acts as the saved state in the same cycle, so the freeze adds
  // exactly the busy cycles and nothing more.
  assign eff_state = (state == HZ_MEM_WAIT) ? ret_state : state;

  always_comb begin
    ctl        = '0;
    next_state = state;
    next_ret   = ret_state;
    next_cnt   = cnt;
    if (mem_busy) begin
      ctl.stall_if = 1'b1;
      ctl.stall_id = 1'b1;
      next_state   = HZ_MEM_WAIT;
      next_ret     = eff_state;
    end else if (branch_taken) begin
      ctl.flush_id = 1'b1;
      next_state   = HZ_IDLE;
      next_ret     = HZ_IDLE;
      next_cnt     = '0;
    end else if (eff_state == HZ_LU_HOLD) begin
      ctl.stall_if  = 1'b1;
      ctl.bubble_ex = 1'b1;
      if (cnt <= CNT_ONE) begin
        next_state = HZ_IDLE;
        next_cnt   = '0;
      end else begin
        next_state = HZ_LU_HOLD;
        next_cnt   = cnt - CNT_ONE;
      end
    end else if (lu) begin
      ctl.stall_if  = 1'b1;
      ctl.bubble_ex = 1'b1;
      if (LOAD_STALL > 1) begin
        next_state = HZ_LU_HOLD;
        next_cnt   = CNT_LOAD;
      end else begin
        next_state = HZ_IDLE;
      end
    end else begin
      next_state = HZ_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HZ_IDLE;
      ret_state <= HZ_IDLE;
      cnt       <= '0;
    end else begin
      state     <= next_state;
      ret_state <= next_ret;
      cnt       <= next_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cycles <= '0;
    else if (stall_if && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end

  hazard_fwd_sel #(.REG_NUM_WIDTH(REG_NUM_WIDTH)) u_fwd_a (
    .src           (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_a_raw)
  );

  hazard_fwd_sel #(.REG_NUM_WIDTH(REG_NUM_WIDTH)) u_fwd_b (
    .src           (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_b_raw)
  );

  // Every output reads as zero while reset is held low, independent of the clock.
  assign stall_if  = reset & ctl.stall_if;
  assign stall_id  = reset & ctl.stall_id;
  assign bubble_ex = reset & ctl.bubble_ex;
  assign flush_id  = reset & ctl.flush_id;
  assign hazard    = stall_if;
  assign fwd_a     = reset ? fwd_a_raw : FWD_REG;
  assign fwd_b     = reset ? fwd_b_raw : FWD_REG;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one instance with single-bubble loads and one
// with three-bubble loads share the same stimulus.
module tb_hazard_ctrl;

  localparam logic [7:0] E_NONE  = 8'h00;
  localparam logic [7:0] E_LU    = 8'hA0;
  localparam logic [7:0] E_BUSY  = 8'hC0;
  localparam logic [7:0] E_FLUSH = 8'h10;
  localparam logic [7:0] A_MEM   = 8'h08;
  localparam logic [7:0] A_WB    = 8'h04;
  localparam logic [7:0] B_MEM   = 8'h02;
  localparam logic [7:0] B_WB    = 8'h01;

  typedef struct packed {
    int         id;
    logic [7:0] e3;
    logic [7:0] e1;
  } sb_entry_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0, ex_rs1 = '0, ex_rs2 = '0, mem_rd = '0, wb_rd = '0;
  logic id_rs1_used = 0, id_rs2_used = 0, ex_mem_read = 0, mem_reg_write = 0, wb_reg_write = 0;
  logic mem_busy = 0, branch_taken = 0;

  logic [4:0] s_id_rs1, s_id_rs2, s_ex_rd, s_ex_rs1, s_ex_rs2, s_mem_rd, s_wb_rd;
  logic s_id_rs1_used, s_id_rs2_used, s_ex_mem_read, s_mem_reg_write, s_wb_reg_write;
  logic s_mem_busy, s_branch_taken;

  logic stall_if3, stall_id3, bubble_ex3, flush_id3, hazard3;
  logic stall_if1, stall_id1, bubble_ex1, flush_id1, hazard1;
  logic [1:0] fwd_a3, fwd_b3, fwd_a1, fwd_b1;
  logic [15:0] stall_cycles3, stall_cycles1;

  int total = 0;
  int bad = 0;
  int step = 0;
  sb_entry_t sb[$];
  sb_entry_t ent;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_NUM_WIDTH(5), .LOAD_STALL(3), .PERF_WIDTH(16)) dut3 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mem_busy(mem_busy), .branch_taken(branch_taken),
    .stall_if(stall_if3), .stall_id(stall_id3), .bubble_ex(bubble_ex3), .flush_id(flush_id3),
    .fwd_a(fwd_a3), .fwd_b(fwd_b3), .hazard(hazard3), .stall_cycles(stall_cycles3)
  );

  hazard_ctrl #(.REG_NUM_WIDTH(5), .LOAD_STALL(1), .PERF_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mem_busy(mem_busy), .branch_taken(branch_taken),
    .stall_if(stall_if1), .stall_id(stall_id1), .bubble_ex(bubble_ex1), .flush_id(flush_id1),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .hazard(hazard1), .stall_cycles(stall_cycles1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearStage();
    s_id_rs1 = '0; s_id_rs2 = '0; s_ex_rd = '0; s_ex_rs1 = '0; s_ex_rs2 = '0;
    s_mem_rd = '0; s_wb_rd = '0; s_id_rs1_used = 0; s_id_rs2_used = 0; s_ex_mem_read = 0;
    s_mem_reg_write = 0; s_wb_reg_write = 0; s_mem_busy = 0; s_branch_taken = 0;
  endtask

  task automatic setLoadUse(input logic on);
    s_ex_mem_read = on; s_ex_rd = 5'd5; s_id_rs1 = 5'd5; s_id_rs1_used = 1'b1;
  endtask

  // Applies the staged inputs just after a rising edge and queues what both DUTs must show.
  task automatic applyStimulus(input logic [7:0] e3, input logic [7:0] e1);
    @(posedge clk);
    #1;
    id_rs1 = s_id_rs1; id_rs2 = s_id_rs2; id_rs1_used = s_id_rs1_used; id_rs2_used = s_id_rs2_used;
    ex_rd = s_ex_rd; ex_mem_read = s_ex_mem_read; ex_rs1 = s_ex_rs1; ex_rs2 = s_ex_rs2;
    mem_rd = s_mem_rd; mem_reg_write = s_mem_reg_write; wb_rd = s_wb_rd; wb_reg_write = s_wb_reg_write;
    mem_busy = s_mem_busy; branch_taken = s_branch_taken;
    step++;
    sb.push_back('{id: step, e3: e3, e1: e1});
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      ent = sb.pop_front();
      checkOutput($sformatf("s%0d_ctl3", ent.id),
                  {24'b0, stall_if3, stall_id3, bubble_ex3, flush_id3, fwd_a3, fwd_b3}, {24'b0, ent.e3});
      checkOutput($sformatf("s%0d_haz3", ent.id), {31'b0, hazard3}, {31'b0, ent.e3[7]});
      checkOutput($sformatf("s%0d_ctl1", ent.id),
                  {24'b0, stall_if1, stall_id1, bubble_ex1, flush_id1, fwd_a1, fwd_b1}, {24'b0, ent.e1});
      checkOutput($sformatf("s%0d_haz1", ent.id), {31'b0, hazard1}, {31'b0, ent.e1[7]});
    end
  end

  task automatic checkPerf(input string tag, input int exp3, input int exp1);
    @(negedge clk);
    checkOutput({tag, "_perf3"}, {16'b0, stall_cycles3}, exp3);
    checkOutput({tag, "_perf1"}, {16'b0, stall_cycles1}, exp1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearStage();
    @(negedge clk);
    checkOutput("reset_ctl3", {28'b0, stall_if3, stall_id3, bubble_ex3, flush_id3}, 0);
    checkOutput("reset_perf3", {16'b0, stall_cycles3}, 0);
    checkOutput("reset_perf1", {16'b0, stall_cycles1}, 0);
    reset = 1'b1;

    // Load-use: one bubble on dut1, three on dut3.
    setLoadUse(1); applyStimulus(E_LU, E_LU);
    s_ex_mem_read = 0; applyStimulus(E_LU, E_NONE);
    applyStimulus(E_LU, E_NONE);
    applyStimulus(E_NONE, E_NONE);
    checkPerf("lu", 3, 1);

    // x0 destination and an unused rs2 never stall.
    clearStage(); s_ex_mem_read = 1; s_id_rs1_used = 1; applyStimulus(E_NONE, E_NONE);
    s_ex_rd = 5'd5; s_id_rs1 = 5'd3; s_id_rs2 = 5'd5; applyStimulus(E_NONE, E_NONE);
    clearStage(); applyStimulus(E_NONE, E_NONE);

    // Memory wait inside the load-use hold.
    setLoadUse(1); applyStimulus(E_LU, E_LU);
    clearStage(); s_mem_busy = 1; applyStimulus(E_BUSY, E_BUSY);
    applyStimulus(E_BUSY, E_BUSY);
    s_mem_busy = 0; applyStimulus(E_LU, E_NONE);
    applyStimulus(E_LU, E_NONE);
    applyStimulus(E_NONE, E_NONE);
    checkPerf("busy", 8, 4);

    // Branch coinciding with a load-use, then a branch during the hold.
    setLoadUse(1); s_branch_taken = 1; applyStimulus(E_FLUSH, E_FLUSH);
    clearStage(); applyStimulus(E_NONE, E_NONE);
    setLoadUse(1); applyStimulus(E_LU, E_LU);
    clearStage(); s_branch_taken = 1; applyStimulus(E_FLUSH, E_FLUSH);
    clearStage(); applyStimulus(E_NONE, E_NONE);
    applyStimulus(E_NONE, E_NONE);
    checkPerf("br", 9, 5);

    // Forwarding selects.
    clearStage(); s_mem_rd = 5'd7; s_wb_rd = 5'd7; s_mem_reg_write = 1; s_wb_reg_write = 1;
    s_ex_rs1 = 5'd7; applyStimulus(A_MEM, A_MEM);
    s_mem_reg_write = 0; s_ex_rs2 = 5'd7; applyStimulus(A_WB | B_WB, A_WB | B_WB);
    s_mem_reg_write = 1; s_mem_rd = 5'd0; applyStimulus(A_WB | B_WB, A_WB | B_WB);
    s_mem_rd = 5'd3; s_wb_rd = 5'd4; s_ex_rs1 = 5'd4; s_ex_rs2 = 5'd3;
    applyStimulus(A_WB | B_MEM, A_WB | B_MEM);
    s_mem_rd = 5'd0; s_wb_rd = 5'd0; s_ex_rs1 = 5'd0; s_ex_rs2 = 5'd0;
    applyStimulus(E_NONE, E_NONE);

    // Asynchronous reset in the middle of the load-use hold.
    clearStage(); s_mem_rd = 5'd7; s_mem_reg_write = 1; s_ex_rs1 = 5'd7;
    setLoadUse(1); applyStimulus(E_LU | A_MEM, E_LU | A_MEM);
    @(posedge clk);
    #1;
    ex_mem_read = 1'b0;
    #1;
    checkOutput("hold_pre_reset", {31'b0, stall_if3}, 1);
    reset = 1'b0;
    #1;
    checkOutput("async_ctl3", {28'b0, stall_if3, stall_id3, bubble_ex3, flush_id3}, 0);
    checkOutput("async_haz3", {31'b0, hazard3}, 0);
    checkOutput("async_fwd3", {30'b0, fwd_a3}, 0);
    checkOutput("async_perf3", {16'b0, stall_cycles3}, 0);
    checkOutput("async_perf1", {16'b0, stall_cycles1}, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    s_ex_mem_read = 0;
    applyStimulus(A_MEM, A_MEM);
    checkPerf("post_reset", 0, 0);
    applyStimulus(A_MEM, A_MEM);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
